// File: rtl/gps_frame_rx.sv
// GPS position frame decoder: reassembles UART bytes into lat/lon fields, drops stalled partial frames.
// Optional GPS_FRAME_CHK_EN adds a trailing XOR checksum byte (10-byte frames).
module gps_frame_rx #(
  parameter int unsigned TIMEOUT_CLKS = 3480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_dv,
  input  logic [7:0]  rx_byte,
  output logic [15:0] latitude_deg,
  output logic [15:0] latitude_min,
  output logic [23:0] longitude_deg,
  output logic [15:0] longitude_min,
  output logic        frame_valid,
  output logic        frame_error,
  output logic        busy,
  output logic [7:0]  frame_cnt
);

`ifdef GPS_FRAME_CHK_EN
  localparam int unsigned FRAME_LEN = 10;
`else
  localparam int unsigned FRAME_LEN = 9;
`endif
  localparam int unsigned BUF_LEN = FRAME_LEN - 1;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned GAP_W   = 16;

  typedef enum logic {IDLE = 1'b0, COLLECT = 1'b1} state_e;

  typedef struct packed {
    logic [15:0] lat_deg;
    logic [15:0] lat_min;
    logic [23:0] lon_deg;
    logic [15:0] lon_min;
  } pos_t;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   byte_idx_q, byte_idx_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [7:0]         shadow_q [BUF_LEN];
  logic [7:0]         shadow_d [BUF_LEN];
  pos_t               pos_q, pos_d, pos_new;
  logic               frame_valid_q, frame_valid_d;
  logic               frame_error_q, frame_error_d;
  logic [7:0]         frame_cnt_q, frame_cnt_d;
  logic               last_byte, timeout, chk_ok;

  assign last_byte = (state_q == COLLECT) && rx_dv && (byte_idx_q == IDX_W'(FRAME_LEN - 1));
  assign timeout   = (state_q == COLLECT) && !rx_dv && (gap_q == GAP_W'(TIMEOUT_CLKS - 1));

  // Final data byte is taken straight from the bus so the frame completes without an extra cycle.
`ifdef GPS_FRAME_CHK_EN
  logic [7:0] chk_acc;

  assign pos_new = {shadow_q[0], shadow_q[1], shadow_q[2], shadow_q[3], shadow_q[4],
                    shadow_q[5], shadow_q[6], shadow_q[7], shadow_q[8]};

  always_comb begin
    chk_acc = rx_byte;
    for (int unsigned i = 0; i < BUF_LEN; i++) chk_acc = chk_acc ^ shadow_q[i];
  end
  assign chk_ok = (chk_acc == 8'h00);
`else
  assign pos_new = {shadow_q[0], shadow_q[1], shadow_q[2], shadow_q[3], shadow_q[4],
                    shadow_q[5], shadow_q[6], shadow_q[7], rx_byte};
  assign chk_ok  = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      byte_idx_q    <= '0;
      gap_q         <= '0;
      pos_q         <= '0;
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      frame_cnt_q   <= '0;
      for (int unsigned i = 0; i < BUF_LEN; i++) shadow_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      byte_idx_q    <= byte_idx_d;
      gap_q         <= gap_d;
      pos_q         <= pos_d;
      frame_valid_q <= frame_valid_d;
      frame_error_q <= frame_error_d;
      frame_cnt_q   <= frame_cnt_d;
      shadow_q      <= shadow_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rx_dv) state_d = COLLECT;
      COLLECT: if (last_byte || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Byte capture, gap timer and atomic publish of a completed frame.
  always_comb begin
    byte_idx_d    = byte_idx_q;
    gap_d         = gap_q;
    shadow_d      = shadow_q;
    pos_d         = pos_q;
    frame_valid_d = 1'b0;
    frame_error_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;

    if (rx_dv) begin
      gap_d      = '0;
      byte_idx_d = byte_idx_q + IDX_W'(1);
      for (int unsigned i = 0; i < BUF_LEN; i++) begin
        if (byte_idx_q == IDX_W'(i)) shadow_d[i] = rx_byte;
      end
    end else if (state_q == COLLECT) begin
      gap_d = gap_q + GAP_W'(1);
    end

    if (last_byte) begin
      byte_idx_d = '0;
      gap_d      = '0;
      if (chk_ok) begin
        pos_d         = pos_new;
        frame_valid_d = 1'b1;
        frame_cnt_d   = frame_cnt_q + 8'd1;
      end else begin
        frame_error_d = 1'b1;
      end
    end else if (timeout) begin
      byte_idx_d    = '0;
      gap_d         = '0;
      frame_error_d = 1'b1;
    end
  end

  assign latitude_deg  = pos_q.lat_deg;
  assign latitude_min  = pos_q.lat_min;
  assign longitude_deg = pos_q.lon_deg;
  assign longitude_min = pos_q.lon_min;
  assign frame_valid   = frame_valid_q;
  assign frame_error   = frame_error_q;
  assign busy          = (state_q == COLLECT);
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_gps_frame_rx.sv
// Self-checking bench for gps_frame_rx: vector table plus scoreboard of expected frame pulses.
module tb_gps_frame_rx;
  localparam int unsigned T = 24;
`ifdef GPS_FRAME_CHK_EN
  localparam int FLEN = 10;
`else
  localparam int FLEN = 9;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_dv;
  logic [7:0]  rx_byte;
  logic [15:0] latitude_deg, latitude_min, longitude_min;
  logic [23:0] longitude_deg;
  logic        frame_valid, frame_error, busy;
  logic [7:0]  frame_cnt;
  logic [71:0] cur_pos;

  gps_frame_rx #(.TIMEOUT_CLKS(T)) dut (
    .clk(clk), .rst(rst), .rx_dv(rx_dv), .rx_byte(rx_byte),
    .latitude_deg(latitude_deg), .latitude_min(latitude_min),
    .longitude_deg(longitude_deg), .longitude_min(longitude_min),
    .frame_valid(frame_valid), .frame_error(frame_error),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;
  assign cur_pos = {latitude_deg, latitude_min, longitude_deg, longitude_min};

  typedef struct {
    bit          err;
    longint      cyc;
    logic [71:0] pos;
    logic [7:0]  cnt;
  } exp_t;

  typedef struct {
    logic [71:0] pos;
    int          gap5;
    logic [15:0] e_lat_deg;
    logic [15:0] e_lat_min;
    logic [23:0] e_lon_deg;
    logic [15:0] e_lon_min;
  } vec_t;

  exp_t        sb[$];
  exp_t        mon_e;
  vec_t        vecs[4];
  longint      cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [71:0] model_pos = '0;
  logic [7:0]  exp_cnt = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte = b;
    rx_dv   = 1'b1;
    @(posedge clk); #1;
    rx_dv   = 1'b0;
  endtask

  task automatic push_valid(input logic [71:0] p);
    exp_t e;
    exp_cnt   = exp_cnt + 8'd1;
    model_pos = p;
    e = '{err: 1'b0, cyc: cyc + 1, pos: p, cnt: exp_cnt};
    sb.push_back(e);
  endtask

  task automatic push_err(input longint delay);
    exp_t e;
    e = '{err: 1'b1, cyc: cyc + delay, pos: model_pos, cnt: exp_cnt};
    sb.push_back(e);
  endtask

  // Sends the nine data bytes (plus checksum when enabled); gap5 idles after byte 5.
  task automatic send_frame(input logic [71:0] pos, input int gap5, input bit bad_chk,
                            input logic [71:0] exp_pos);
    logic [7:0] b;
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < 9; i++) begin
      b = pos[71-8*i -: 8];
      x = x ^ b;
      if (i == 8 && FLEN == 9) push_valid(exp_pos);
      send_byte(b);
      if (i == 5 && gap5 > 0) idle(gap5);
    end
    if (FLEN == 10) begin
      if (bad_chk) push_err(1); else push_valid(exp_pos);
      send_byte(bad_chk ? (x ^ 8'h01) : x);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pos"}, cur_pos, 72'h0);
    check({tag, "_cnt"}, 72'(frame_cnt), 72'h0);
    check({tag, "_busy"}, 72'(busy), 72'h0);
    check({tag, "_valid"}, 72'(frame_valid), 72'h0);
    check({tag, "_error"}, 72'(frame_error), 72'h0);
  endtask

  // Every pulse must match the oldest outstanding expectation, in kind, cycle and content.
  always @(negedge clk) begin
    if (!rst && (frame_valid || frame_error)) begin
      check("pulse_exclusive", 72'(frame_valid & frame_error), 72'h0);
      check("busy_at_pulse", 72'(busy), 72'h0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: valid=%0b error=%0b expected none (cycle %0d)",
                 frame_valid, frame_error, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("pulse_kind_err", 72'(frame_error), 72'(mon_e.err));
        check("pulse_cycle", 72'(cyc), 72'(mon_e.cyc));
        check("pulse_pos", cur_pos, mon_e.pos);
        check("pulse_cnt", 72'(frame_cnt), 72'(mon_e.cnt));
      end
    end
  end

  initial begin
    vecs[0] = '{72'h123456789ABCDEF011, 0, 16'h1234, 16'h5678, 24'h9ABCDE, 16'hF011};
    vecs[1] = '{72'hFFFFFFFFFFFFFFFFFF, 0, 16'hFFFF, 16'hFFFF, 24'hFFFFFF, 16'hFFFF};
    vecs[2] = '{72'hA5A50F0FC33C96695A, int'(T) - 1, 16'hA5A5, 16'h0F0F, 24'hC33C96, 16'h695A};
    vecs[3] = '{72'h010203040506070809, 3, 16'h0102, 16'h0304, 24'h050607, 16'h0809};

    rst = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_zero("reset");

    // Table: each frame must publish the literal field values; row 2 lands a byte on the expiry cycle.
    for (int r = 0; r < 4; r++) begin
      send_frame(vecs[r].pos, vecs[r].gap5, 1'b0,
                 {vecs[r].e_lat_deg, vecs[r].e_lat_min, vecs[r].e_lon_deg, vecs[r].e_lon_min});
      idle(2);
      check("row_pos", cur_pos,
            {vecs[r].e_lat_deg, vecs[r].e_lat_min, vecs[r].e_lon_deg, vecs[r].e_lon_min});
      check("row_cnt", 72'(frame_cnt), 72'(r + 1));
    end

    // Partial frame of 4 bytes, then silence: error exactly T cycles after the 4th byte.
    for (int i = 0; i < 4; i++) begin
      if (i == 3) push_err(1 + longint'(T));
      send_byte(8'hC0 + 8'(i));
    end
    check("timeout_busy_hi", 72'(busy), 72'h1);
    idle(int'(T) + 3);
    check("timeout_busy_lo", 72'(busy), 72'h0);
    check("timeout_pos_kept", cur_pos, 72'h010203040506070809);
    check("timeout_cnt_kept", 72'(frame_cnt), 72'h4);
    send_frame(72'h0BADC0FFEE12345678, 0, 1'b0, 72'h0BADC0FFEE12345678);
    idle(2);
    check("after_timeout_pos", cur_pos, 72'h0BADC0FFEE12345678);

    // Reset after byte 6: everything clears, no error pulse follows.
    for (int i = 0; i < 7; i++) send_byte(8'h30 + 8'(i));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = '0;
    model_pos = '0;
    check_zero("midreset");
    idle(int'(T) + 5);

    // Back-to-back: byte 0 of frame 2 is driven during frame 1's valid cycle.
    send_frame(72'h111111111111111111, 0, 1'b0, 72'h111111111111111111);
    send_frame(72'h2468ACE013579BDF02, 0, 1'b0, 72'h2468ACE013579BDF02);
    idle(3);
    check("b2b_cnt", 72'(frame_cnt), 72'h2);
    check("b2b_pos", cur_pos, 72'h2468ACE013579BDF02);

`ifdef GPS_FRAME_CHK_EN
    send_frame(72'h123456789ABCDEF011, 0, 1'b1, 72'h0);
    idle(3);
    check("badchk_cnt", 72'(frame_cnt), 72'h2);
    check("badchk_pos", cur_pos, 72'h2468ACE013579BDF02);
`endif

    // 256 good frames from reset wrap the counter back to zero.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = '0;
    model_pos = '0;
    for (int f = 0; f < 256; f++) begin
      logic [71:0] p;
      p = {8'($urandom), 32'($urandom), 32'($urandom)};
      send_frame(p, 0, 1'b0, p);
    end
    idle(3);
    check("wrap_cnt", 72'(frame_cnt), 72'h0);

    idle(int'(T) + 5);
    check("scoreboard_empty", 72'(sb.size()), 72'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
